icache_refill: RTL and testbench



---
 rtl/icache_refill_pkg.sv | 52 +++++
 rtl/icache_refill_if.sv | 62 ++++++
 rtl/icache_refill_buf.sv | 42 ++++
 rtl/icache_refill.sv | 146 ++++++++++++++
 tb/tb_icache_refill.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/icache_refill_pkg.sv
// icache_refill_pkg: shared sizes, address-field helpers and FSM state type
// for the instruction-cache line refill engine.
// Optional feature macro: ICACHE_REFILL_CRITICAL_WORD_FIRST_EN (see icache_refill.sv).
package icache_refill_pkg;

   localparam int WNUM       = 8;
   localparam int LNUM       = 64;
   localparam int WORD_WIDTH = 32;
   localparam int ADDR_WIDTH = 32;
   localparam int BOFFSZ     = 2;
   localparam int WADDRSZ    = $clog2(WNUM);
   localparam int LADDRSZ    = $clog2(LNUM);

   typedef logic [WORD_WIDTH-1:0] word_t;
   typedef logic [ADDR_WIDTH-1:0] addr_t;
   typedef logic [LADDRSZ-1:0]    laddr_t;
   typedef logic [WADDRSZ-1:0]    waddr_t;
   typedef word_t [WNUM-1:0]      line_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      RECV  = 2'd2,
      WRITE = 2'd3
   } refill_state_t;

   // Line index sits directly above the byte and word offsets.
   function automatic laddr_t line_index(addr_t a);
      return a[BOFFSZ+WADDRSZ +: LADDRSZ];
   endfunction

   function automatic waddr_t word_offset(addr_t a);
      return a[BOFFSZ +: WADDRSZ];
   endfunction

   // Clears byte and word offset: start of the cache line.
   function automatic addr_t line_align(addr_t a);
      addr_t m;
      m = a;
      m[BOFFSZ+WADDRSZ-1:0] = '0;
      return m;
   endfunction

   // Clears only the byte offset: start of the missed word.
   function automatic addr_t word_align(addr_t a);
      addr_t m;
      m = a;
      m[BOFFSZ-1:0] = '0;
      return m;
   endfunction

endpackage

// File: rtl/icache_refill_if.sv
// icache_refill_if: miss request, memory burst and line-write signals of the
// refill engine. The master modport is the engine, the slave modport is its
// environment (icache controller, memory and data array).
// Optional feature macro: ICACHE_REFILL_CRITICAL_WORD_FIRST_EN adds crit_* signals.
interface icache_refill_if;
   import icache_refill_pkg::*;

   logic   miss_valid;
   logic   miss_ready;
   addr_t  miss_addr;

   logic   mem_req_valid;
   logic   mem_req_ready;
   addr_t  mem_req_addr;

   logic   mem_resp_valid;
   logic   mem_resp_ready;
   word_t  mem_resp_data;
   logic   mem_resp_last;

   logic   wr_en;
   laddr_t wr_laddr;
   line_t  wr_data;

   logic   refill_done;
   logic   busy;
   logic   err;

`ifdef ICACHE_REFILL_CRITICAL_WORD_FIRST_EN
   logic   crit_valid;
   word_t  crit_data;
`endif

   modport master (
`ifdef ICACHE_REFILL_CRITICAL_WORD_FIRST_EN
      output crit_valid, crit_data,
`endif
      input  miss_valid, miss_addr,
      output miss_ready,
      output mem_req_valid, mem_req_addr,
      input  mem_req_ready,
      input  mem_resp_valid, mem_resp_data, mem_resp_last,
      output mem_resp_ready,
      output wr_en, wr_laddr, wr_data,
      output refill_done, busy, err
   );

   modport slave (
`ifdef ICACHE_REFILL_CRITICAL_WORD_FIRST_EN
      input  crit_valid, crit_data,
`endif
      output miss_valid, miss_addr,
      input  miss_ready,
      input  mem_req_valid, mem_req_addr,
      output mem_req_ready,
      output mem_resp_valid, mem_resp_data, mem_resp_last,
      input  mem_resp_ready,
      input  wr_en, wr_laddr, wr_data,
      input  refill_done, busy, err
   );

endinterface

// File: rtl/icache_refill_buf.sv
// icache_refill_buf: WNUM-entry line buffer. Beats are written at a pointer
// that can be preloaded (critical-word-first start) and wraps modulo WNUM;
// the whole line is read in parallel for the single-cycle array write.
module icache_refill_buf
   import icache_refill_pkg::*;
(
   input  logic   clk,
   input  logic   rst_n,
   input  logic   load,
   input  waddr_t start_ptr,
   input  logic   wr,
   input  word_t  wdata,
   output line_t  rd_line
);

   waddr_t ptr;
   line_t  mem;

   // Write pointer: preload at miss acceptance, step per beat; WNUM is a power
   // of two so the natural overflow of the pointer is the modulo wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (load) begin
         ptr <= start_ptr;
      end else if (wr) begin
         ptr <= ptr + 1'b1;
      end
   end

   // Storage: reset clears it so an aborted partial line never survives.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem <= '0;
      end else if (wr) begin
         mem[ptr] <= wdata;
      end
   end

   assign rd_line = mem;

endmodule

// File: rtl/icache_refill.sv
// icache_refill: accepts one icache miss at a time, issues one WNUM-beat burst
// read, collects the beats into a line buffer and writes the full line into the
// data array in a single cycle.
// Optional feature macro: ICACHE_REFILL_CRITICAL_WORD_FIRST_EN -- the burst
// starts at the missed word (wrapping burst), the buffer pointer starts at that
// word offset, and crit_valid/crit_data forward the first beat.
module icache_refill
   import icache_refill_pkg::*;
(
   input logic             clk,
   input logic             rst_n,
   icache_refill_if.master bus
);

   refill_state_t state;
   refill_state_t state_next;

   logic   ready_en;
   laddr_t line_q;
   addr_t  req_addr_q;
   waddr_t cnt;

   logic   accept_miss;
   logic   beat_hs;
   logic   last_beat;
   waddr_t start_ptr;
   line_t  buf_line;

   assign accept_miss = (state == IDLE) && ready_en && bus.miss_valid;
   assign beat_hs     = (state == RECV) && bus.mem_resp_valid;
   assign last_beat   = (cnt == waddr_t'(WNUM-1));

`ifdef ICACHE_REFILL_CRITICAL_WORD_FIRST_EN
   assign start_ptr = word_offset(bus.miss_addr);
`else
   assign start_ptr = '0;
`endif

   icache_refill_buf u_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (accept_miss),
      .start_ptr (start_ptr),
      .wr        (beat_hs),
      .wdata     (bus.mem_resp_data),
      .rd_line   (buf_line)
   );

   // State register; reset drops straight back to IDLE, abandoning any refill.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Keeps miss_ready low while reset is asserted and raises it one edge after.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready_en <= 1'b0;
      end else begin
         ready_en <= 1'b1;
      end
   end

   // Miss capture and beat counting; the counter, not mem_resp_last, decides
   // when the line is complete.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         line_q     <= '0;
         req_addr_q <= '0;
         cnt        <= '0;
      end else if (accept_miss) begin
         line_q     <= line_index(bus.miss_addr);
`ifdef ICACHE_REFILL_CRITICAL_WORD_FIRST_EN
         req_addr_q <= word_align(bus.miss_addr);
`else
         req_addr_q <= line_align(bus.miss_addr);
`endif
         cnt        <= '0;
      end else if (beat_hs) begin
         cnt <= cnt + 1'b1;
      end
   end

   // Next-state logic: IDLE -> REQ -> RECV -> WRITE -> IDLE.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept_miss) state_next = REQ;
         REQ:     if (bus.mem_req_ready) state_next = RECV;
         RECV:    if (beat_hs && last_beat) state_next = WRITE;
         WRITE:   state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Outputs decoded from state; idle values are all zero so reset drives zero.
   always_comb begin
      bus.miss_ready     = 1'b0;
      bus.mem_req_valid  = 1'b0;
      bus.mem_req_addr   = '0;
      bus.mem_resp_ready = 1'b0;
      bus.wr_en          = 1'b0;
      bus.wr_laddr       = '0;
      bus.wr_data        = '0;
      bus.refill_done    = 1'b0;
      bus.busy           = 1'b1;
      bus.err            = 1'b0;
`ifdef ICACHE_REFILL_CRITICAL_WORD_FIRST_EN
      bus.crit_valid     = 1'b0;
      bus.crit_data      = '0;
`endif
      case (state)
         IDLE: begin
            bus.busy       = 1'b0;
            bus.miss_ready = ready_en;
         end
         REQ: begin
            bus.mem_req_valid = 1'b1;
            bus.mem_req_addr  = req_addr_q;
         end
         RECV: begin
            bus.mem_resp_ready = 1'b1;
            if (bus.mem_resp_valid) begin
               bus.err = (bus.mem_resp_last != last_beat);
`ifdef ICACHE_REFILL_CRITICAL_WORD_FIRST_EN
               if (cnt == '0) begin
                  bus.crit_valid = 1'b1;
                  bus.crit_data  = bus.mem_resp_data;
               end
`endif
            end
         end
         WRITE: begin
            bus.wr_en       = 1'b1;
            bus.refill_done = 1'b1;
            bus.wr_laddr    = line_q;
            bus.wr_data     = buf_line;
         end
         default: bus.busy = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_icache_refill.sv
// tb_icache_refill: directed refill scenarios with a scoreboard. Stimulus tasks
// push the expected request address, per-beat err/crit values and line write
// into queues; an independent negedge monitor pops and compares them whenever
// the DUT presents a handshake or write.
module tb_icache_refill;
   import icache_refill_pkg::*;

   localparam int TIMEOUT = 200;

   typedef struct {
      laddr_t laddr;
      line_t  line;
   } wr_exp_t;

   typedef struct {
      logic  err;
      logic  crit;
      word_t data;
   } beat_exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   icache_refill_if bus ();

   icache_refill dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   addr_t     exp_req[$];
   wr_exp_t   exp_wr[$];
   beat_exp_t exp_beat[$];

   bit hold_test = 0;
   int hold_accepts = 0;

   task automatic check_output(string name, logic [WNUM*WORD_WIDTH-1:0] act,
                               logic [WNUM*WORD_WIDTH-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail_now(string name);
      checks++;
      errors++;
      $display("[TB] FAIL %s: event not expected or bound expired", name);
   endtask

   // Scoreboard monitor.
   bit    in_flight = 0, ready_leak = 0, miss_hs_prev = 0, wr_prev = 0, req_stall = 0;
   addr_t req_prev;
   int    last_beat_cyc = -10;
   int    last_wr_cyc = -10;

   always @(negedge clk) begin
      if (!rst_n) begin
         in_flight = 0; ready_leak = 0; miss_hs_prev = 0; wr_prev = 0; req_stall = 0;
      end else begin
         if (miss_hs_prev) begin
            check_output("req_valid_after_miss", bus.mem_req_valid, 1);
            check_output("busy_after_miss", bus.busy, 1);
         end
         if (wr_prev) check_output("ready_after_write", bus.miss_ready, 1);
         if (in_flight && bus.miss_ready) ready_leak = 1;

         miss_hs_prev = bus.miss_valid && bus.miss_ready;
         if (miss_hs_prev) begin
            if (hold_test && hold_accepts > 0)
               check_output("hold_accept_cycle", cyc, last_wr_cyc + 1);
            if (hold_test) hold_accepts++;
            in_flight = 1;
         end

         if (bus.mem_req_valid) begin
            if (req_stall) check_output("req_addr_stable", bus.mem_req_addr, req_prev);
            if (bus.mem_req_ready) begin
               if (exp_req.size() == 0) fail_now("unexpected_req");
               else check_output("req_addr", bus.mem_req_addr, exp_req.pop_front());
               req_stall = 0;
            end else begin
               req_stall = 1;
               req_prev  = bus.mem_req_addr;
            end
         end else begin
            req_stall = 0;
         end

         if (bus.mem_resp_valid && bus.mem_resp_ready) begin
            last_beat_cyc = cyc;
            if (exp_beat.size() == 0) begin
               fail_now("unexpected_beat");
            end else begin
               beat_exp_t b;
               b = exp_beat.pop_front();
               check_output("beat_err", bus.err, b.err);
`ifdef ICACHE_REFILL_CRITICAL_WORD_FIRST_EN
               check_output("crit_valid", bus.crit_valid, b.crit);
               check_output("crit_data", bus.crit_data, b.crit ? b.data : '0);
`endif
            end
         end else if (bus.err) begin
            fail_now("err_without_beat");
         end

         if (bus.wr_en || bus.refill_done) begin
            if (exp_wr.size() == 0) begin
               fail_now("unexpected_write");
            end else begin
               wr_exp_t w;
               w = exp_wr.pop_front();
               check_output("wr_laddr", bus.wr_laddr, w.laddr);
               check_output("wr_data", bus.wr_data, w.line);
               check_output("wr_en", bus.wr_en, 1);
               check_output("refill_done", bus.refill_done, 1);
               check_output("wr_timing", cyc, last_beat_cyc + 1);
               check_output("ready_low_during_refill", ready_leak, 0);
            end
            in_flight = 0; ready_leak = 0; wr_prev = 1; last_wr_cyc = cyc;
         end else begin
            wr_prev = 0;
         end
      end
   end

   task automatic check_reset_outputs();
      check_output("rst_miss_ready", bus.miss_ready, 0);
      check_output("rst_req_valid", bus.mem_req_valid, 0);
      check_output("rst_resp_ready", bus.mem_resp_ready, 0);
      check_output("rst_wr_en", bus.wr_en, 0);
      check_output("rst_refill_done", bus.refill_done, 0);
      check_output("rst_busy", bus.busy, 0);
      check_output("rst_err", bus.err, 0);
      check_output("rst_req_addr", bus.mem_req_addr, 0);
      check_output("rst_wr_laddr", bus.wr_laddr, 0);
      check_output("rst_wr_data", bus.wr_data, 0);
   endtask

   // Queue the expectations of one refill; word k of the line is base+k.
   task automatic push_exp(addr_t req, laddr_t laddr, word_t base, int start,
                           int bad_last, int count, bit do_write);
      wr_exp_t w;
      exp_req.push_back(req);
      for (int i = 0; i < count; i++) begin
         beat_exp_t b;
         logic last;
         last   = (bad_last >= 0) ? (i == bad_last) : (i == WNUM-1);
         b.err  = (last != (i == WNUM-1));
         b.crit = (i == 0);
         b.data = base + word_t'((start + i) % WNUM);
         exp_beat.push_back(b);
      end
      if (do_write) begin
         w.laddr = laddr;
         for (int k = 0; k < WNUM; k++) w.line[k] = base + word_t'(k);
         exp_wr.push_back(w);
      end
   endtask

   task automatic do_miss(addr_t a, bit keep);
      bit hs;
      int n;
      n = 0;
      bus.miss_valid = 1'b1;
      bus.miss_addr  = a;
      do begin
         @(negedge clk); hs = bus.miss_ready;
         @(posedge clk); #1; n++;
      end while (!hs && n < TIMEOUT);
      if (!hs) fail_now("miss_accept_timeout");
      if (!keep) bus.miss_valid = 1'b0;
   endtask

   task automatic mem_request(bit stall);
      bit hs;
      int n;
      n = 0;
      do begin
         bus.mem_req_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         @(negedge clk); hs = bus.mem_req_valid && bus.mem_req_ready;
         @(posedge clk); #1; n++;
      end while (!hs && n < TIMEOUT);
      if (!hs) fail_now("req_timeout");
      bus.mem_req_ready = 1'b0;
   endtask

   task automatic mem_beats(word_t base, int start, bit stall, int bad_last, int count);
      bit hs;
      int i, n;
      i = 0; n = 0;
      while (i < count && n < TIMEOUT) begin
         bus.mem_resp_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         bus.mem_resp_data  = base + word_t'((start + i) % WNUM);
         bus.mem_resp_last  = (bad_last >= 0) ? (i == bad_last) : (i == WNUM-1);
         @(negedge clk); hs = bus.mem_resp_valid && bus.mem_resp_ready;
         @(posedge clk); #1; n++;
         if (hs) i++;
      end
      if (i < count) fail_now("beat_timeout");
      bus.mem_resp_valid = 1'b0;
      bus.mem_resp_last  = 1'b0;
   endtask

   // One refill; req_l/req_c are the line- and word-aligned request addresses.
   task automatic apply_stimulus(addr_t a, addr_t req_l, addr_t req_c, int off,
                                 laddr_t laddr, word_t base, bit stall,
                                 int bad_last, int abort_after);
      addr_t req;
      int    start, count;
`ifdef ICACHE_REFILL_CRITICAL_WORD_FIRST_EN
      req = req_c; start = off;
`else
      req = req_l; start = 0;
      if (off < 0 || req_c == '1) $display("[TB] unused vector field");
`endif
      count = (abort_after > 0) ? abort_after : WNUM;
      push_exp(req, laddr, base, start, bad_last, count, abort_after == 0);
      do_miss(a, 1'b0);
      mem_request(stall);
      mem_beats(base, start, stall, bad_last, count);
      if (abort_after > 0) begin
         rst_n = 1'b0;
         @(negedge clk);
         check_reset_outputs();
         @(posedge clk); #1;
         rst_n = 1'b1;
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      int hold_start_b;
      rst_n = 1'b0;
      bus.miss_valid = 0; bus.miss_addr = '0;
      bus.mem_req_ready = 0;
      bus.mem_resp_valid = 0; bus.mem_resp_data = '0; bus.mem_resp_last = 0;
      @(negedge clk);
      check_reset_outputs();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_output("ready_after_reset", bus.miss_ready, 1);
      @(posedge clk); #1;

      $display("[TB] basic zero-wait refill");
      apply_stimulus(32'h0000_1234, 32'h0000_1220, 32'h0000_1234, 5, 6'h11, 32'hA0, 0, -1, 0);
      $display("[TB] stalled refills and address extremes");
      apply_stimulus(32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 0, 6'h00, 32'h100, 1, -1, 0);
      apply_stimulus(32'hFFFF_FFFC, 32'hFFFF_FFE0, 32'hFFFF_FFFC, 7, 6'h3F, 32'hDEAD_0000, 1, -1, 0);
      $display("[TB] early last flag");
      apply_stimulus(32'h0000_2048, 32'h0000_2040, 32'h0000_2048, 2, 6'h02, 32'h300, 0, 3, 0);
      $display("[TB] reset mid-refill then normal refill");
      apply_stimulus(32'h0000_4FE0, 32'h0000_4FE0, 32'h0000_4FE0, 0, 6'h3F, 32'h400, 0, -1, 4);
      apply_stimulus(32'h0000_0080, 32'h0000_0080, 32'h0000_0080, 0, 6'h04, 32'h500, 1, -1, 0);

      $display("[TB] miss_valid held high across two refills");
      hold_test = 1;
`ifdef ICACHE_REFILL_CRITICAL_WORD_FIRST_EN
      push_exp(32'h0000_1000, 6'h00, 32'h600, 0, -1, WNUM, 1);
      push_exp(32'h0000_103C, 6'h01, 32'h700, 7, -1, WNUM, 1);
      hold_start_b = 7;
`else
      push_exp(32'h0000_1000, 6'h00, 32'h600, 0, -1, WNUM, 1);
      push_exp(32'h0000_1020, 6'h01, 32'h700, 0, -1, WNUM, 1);
      hold_start_b = 0;
`endif
      do_miss(32'h0000_1000, 1'b1);
      bus.miss_addr = 32'h0000_103C;
      mem_request(0);
      mem_beats(32'h600, 0, 0, -1, WNUM);
      do_miss(32'h0000_103C, 1'b0);
      mem_request(0);
      mem_beats(32'h700, hold_start_b, 0, -1, WNUM);
      repeat (3) @(posedge clk);
      hold_test = 0;
      check_output("hold_accept_count", hold_accepts, 2);

      repeat (5) @(posedge clk);
      check_output("req_queue_empty", exp_req.size(), 0);
      check_output("beat_queue_empty", exp_beat.size(), 0);
      check_output("write_queue_empty", exp_wr.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL global_timeout: simulation did not finish");
      $fatal(1, "[TB] timeout");
   end

endmodule
